// File: rtl/ex_result_stage.sv
// ex_result_stage: EX/MEM result register with WISC ADD/SUB saturation,
// N/Z/V flag register with per-opcode update rules, stall/flush control and
// a saturating overflow event counter.
module ex_result_stage #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [3:0]           op_in,
  input  logic [WIDTH-1:0]     alu_in,
  input  logic                 ovfl_in,
  input  logic                 a_msb_in,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 ovf_clr,
  output logic [WIDTH-1:0]     result_q,
  output logic                 valid_q,
  output logic [3:0]           op_q,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_v,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_NONE  = 2'd2
  } op_class_e;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  op_class_e              op_class;
  logic [WIDTH-1:0]       sat;
  logic                   accept;

  logic [WIDTH-1:0]       result_d;
  logic                   valid_d;
  logic [3:0]             op_d;
  logic                   flag_n_d;
  logic                   flag_z_d;
  logic                   flag_v_d;
  logic [OVF_CNT_W-1:0]   ovf_count_d;

  // Classify the incoming opcode by its flag-update behaviour.
  always_comb begin
    op_class = CLS_NONE;
    case (op_in)
      4'b0000, 4'b0001:                   op_class = CLS_ARITH;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: op_class = CLS_LOGIC;
      default:                            op_class = CLS_NONE;
    endcase
  end

  // Saturate ADD/SUB on overflow; direction follows the A operand sign.
  always_comb begin
    sat = alu_in;
    if (op_class == CLS_ARITH && ovfl_in) begin
      sat = a_msb_in ? SAT_NEG : SAT_POS;
    end
  end

  assign accept = valid_in & ~stall & ~flush;

  // Next-state for the result register, flags and overflow counter.
  always_comb begin
    result_d    = result_q;
    valid_d     = valid_q;
    op_d        = op_q;
    flag_n_d    = flag_n;
    flag_z_d    = flag_z;
    flag_v_d    = flag_v;
    ovf_count_d = ovf_count;

    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (valid_in) begin
        result_d = sat;
        op_d     = op_in;
        valid_d  = 1'b1;
        case (op_class)
          CLS_ARITH: begin
            flag_n_d = sat[WIDTH-1];
            flag_z_d = (sat == '0);
            flag_v_d = ovfl_in;
          end
          CLS_LOGIC: flag_z_d = (sat == '0);
          default:   ;
        endcase
      end else begin
        valid_d = 1'b0;
      end
    end

    if (ovf_clr) begin
      ovf_count_d = '0;
    end else if (accept && op_class == CLS_ARITH && ovfl_in && ovf_count != '1) begin
      ovf_count_d = ovf_count + OVF_CNT_W'(1);
    end
  end

  // Stage registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
      ovf_count <= '0;
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      flag_n    <= flag_n_d;
      flag_z    <= flag_z_d;
      flag_v    <= flag_v_d;
      ovf_count <= ovf_count_d;
    end
  end

endmodule
